// File: rtl/pipe_pkg.sv
// Shared pipeline definitions: sequencer state encoding, NOP and x0 constants.
package pipe_pkg;

  typedef enum logic [1:0] {
    ST_RUN      = 2'd0,
    ST_MEM_WAIT = 2'd1,
    ST_HALT     = 2'd2
  } state_e;

  // addi x0, x0, 0
  localparam logic [31:0] NOP_INSN = 32'h0000_0013;
  localparam logic [4:0]  REG_X0   = 5'd0;

endpackage

// File: rtl/hazard_detect.sv
// Load-use hazard compare between the ID instruction's sources and the EX load.
module hazard_detect
  import pipe_pkg::*;
(
  input  logic [4:0] id_rs1,
  input  logic [4:0] id_rs2,
  input  logic       id_use_rs1,
  input  logic       id_use_rs2,
  input  logic [4:0] ex_rd,
  input  logic       ex_mem_read,
  output logic       load_use_c
);

  logic rs1_hit_c;
  logic rs2_hit_c;

  // x0 is hardwired to zero, so a load targeting it never blocks a consumer
  always_comb begin
    rs1_hit_c  = id_use_rs1 && (id_rs1 == ex_rd);
    rs2_hit_c  = id_use_rs2 && (id_rs2 == ex_rd);
    load_use_c = ex_mem_read && (ex_rd != REG_X0) && (rs1_hit_c || rs2_hit_c);
  end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Pipeline sequencer: per-boundary load enables, bubble strobes, memory-wait /
// timeout / halt FSM and a saturating stall-cycle counter.
module pipe_hazard_ctrl
  import pipe_pkg::*;
#(
  parameter int unsigned MEM_TIMEOUT = 64,
  parameter int unsigned CNT_W       = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [4:0]       id_rs1,
  input  logic [4:0]       id_rs2,
  input  logic             id_useRs1,
  input  logic             id_useRs2,
  input  logic [4:0]       ex_rd,
  input  logic             ex_memRead,
  input  logic             ex_redirect,
  input  logic             imem_ready,
  input  logic             me_memReq,
  input  logic             dmem_ready,
  input  logic             halt_req,
  input  logic             resume,
  output logic             pc_en,
  output logic             if_id_en,
  output logic             id_ex_en,
  output logic             ex_me_en,
  output logic             me_wb_en,
  output logic             if_id_bubble,
  output logic             id_ex_bubble,
  output logic             mem_err,
  output logic             halted,
  output logic [CNT_W-1:0] stall_cnt
);

  localparam int unsigned TMO_W = $clog2(MEM_TIMEOUT + 1);

  state_e             state_q, state_d;
  logic [TMO_W-1:0]   tmo_q, tmo_d;
  logic               mem_err_q, mem_err_d;
  logic [CNT_W-1:0]   stall_cnt_q, stall_cnt_d;

  logic load_use_c;
  logic flow_pc_c, flow_if_id_c, flow_id_ex_c, flow_ex_me_c, flow_me_wb_c;
  logic flow_if_id_bub_c, flow_id_ex_bub_c;

  hazard_detect u_hazard_detect (
    .id_rs1      (id_rs1),
    .id_rs2      (id_rs2),
    .id_use_rs1  (id_useRs1),
    .id_use_rs2  (id_useRs2),
    .ex_rd       (ex_rd),
    .ex_mem_read (ex_memRead),
    .load_use_c  (load_use_c)
  );

  // Enables when data memory is not holding the pipe: redirect > load-use > fetch miss
  always_comb begin
    flow_pc_c        = 1'b1;
    flow_if_id_c     = 1'b1;
    flow_id_ex_c     = 1'b1;
    flow_ex_me_c     = 1'b1;
    flow_me_wb_c     = 1'b1;
    flow_if_id_bub_c = 1'b0;
    flow_id_ex_bub_c = 1'b0;
    if (ex_redirect) begin
      flow_if_id_bub_c = 1'b1;
      flow_id_ex_bub_c = 1'b1;
    end else if (load_use_c) begin
      flow_pc_c        = 1'b0;
      flow_if_id_c     = 1'b0;
      flow_id_ex_bub_c = 1'b1;
    end else if (!imem_ready) begin
      flow_pc_c        = 1'b0;
      flow_if_id_bub_c = 1'b1;
    end
  end

  // FSM next state, timeout tracking, outgoing enables and stall accounting
  always_comb begin
    state_d      = state_q;
    tmo_d        = tmo_q;
    mem_err_d    = mem_err_q;
    stall_cnt_d  = stall_cnt_q;
    pc_en        = 1'b0;
    if_id_en     = 1'b0;
    id_ex_en     = 1'b0;
    ex_me_en     = 1'b0;
    me_wb_en     = 1'b0;
    if_id_bubble = 1'b0;
    id_ex_bubble = 1'b0;

    unique case (state_q)
      ST_RUN: begin
        if (me_memReq && !dmem_ready) begin
          state_d = ST_MEM_WAIT;
          tmo_d   = TMO_W'(1);
        end else begin
          pc_en        = flow_pc_c;
          if_id_en     = flow_if_id_c;
          id_ex_en     = flow_id_ex_c;
          ex_me_en     = flow_ex_me_c;
          me_wb_en     = flow_me_wb_c;
          if_id_bubble = flow_if_id_bub_c;
          id_ex_bubble = flow_id_ex_bub_c;
          if (halt_req) state_d = ST_HALT;
        end
      end
      ST_MEM_WAIT: begin
        // a completion in the final allowed cycle still beats the timeout
        if (dmem_ready) begin
          pc_en        = flow_pc_c;
          if_id_en     = flow_if_id_c;
          id_ex_en     = flow_id_ex_c;
          ex_me_en     = flow_ex_me_c;
          me_wb_en     = flow_me_wb_c;
          if_id_bubble = flow_if_id_bub_c;
          id_ex_bubble = flow_id_ex_bub_c;
          state_d      = ST_RUN;
          tmo_d        = '0;
        end else if (tmo_q >= TMO_W'(MEM_TIMEOUT)) begin
          mem_err_d = 1'b1;
          state_d   = ST_HALT;
          tmo_d     = '0;
        end else begin
          tmo_d = tmo_q + TMO_W'(1);
        end
      end
      ST_HALT: begin
        if (resume) state_d = ST_RUN;
      end
      default: begin
        state_d = ST_RUN;
        tmo_d   = '0;
      end
    endcase

    if (rst) begin
      pc_en        = 1'b0;
      if_id_en     = 1'b0;
      id_ex_en     = 1'b0;
      ex_me_en     = 1'b0;
      me_wb_en     = 1'b0;
      if_id_bubble = 1'b0;
      id_ex_bubble = 1'b0;
    end

    if (!rst && (state_q != ST_HALT) && !pc_en && (stall_cnt_q != {CNT_W{1'b1}})) begin
      stall_cnt_d = stall_cnt_q + CNT_W'(1);
    end
  end

  // State and counter registers; reset abandons any outstanding access
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_RUN;
      tmo_q       <= '0;
      mem_err_q   <= 1'b0;
      stall_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      tmo_q       <= tmo_d;
      mem_err_q   <= mem_err_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign mem_err   = mem_err_q;
  assign halted    = (state_q == ST_HALT);
  assign stall_cnt = stall_cnt_q;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Bench for pipe_hazard_ctrl: directed vector table, then randomized run vs a reference model.
module tb_pipe_hazard_ctrl;

  localparam int unsigned TB_TMO   = 4;
  localparam int unsigned TB_CNT_W = 4;
  localparam int          CNT_MAX  = (1 << TB_CNT_W) - 1;
  localparam int          N_RAND   = 3000;

  typedef struct packed {
    logic       rst;
    logic       redir;
    logic       imr;
    logic       memreq;
    logic       dr;
    logic       hreq;
    logic       resume;
    logic       exmr;
    logic [4:0] exrd;
    logic       u1;
    logic [4:0] rs1;
    logic       u2;
    logic [4:0] rs2;
  } in_t;

  typedef struct {
    string      name;
    in_t        in;
    logic [6:0] en;   // {pc, if_id, id_ex, ex_me, me_wb, if_id_bubble, id_ex_bubble}
    logic       err;
    logic       hlt;
    int         cnt;
  } vec_t;

  logic clk;
  logic rst;
  logic [4:0] id_rs1, id_rs2, ex_rd;
  logic id_useRs1, id_useRs2, ex_memRead, ex_redirect, imem_ready;
  logic me_memReq, dmem_ready, halt_req, resume;
  logic pc_en, if_id_en, id_ex_en, ex_me_en, me_wb_en, if_id_bubble, id_ex_bubble;
  logic mem_err, halted;
  logic [TB_CNT_W-1:0] stall_cnt;

  int total;
  int bad;

  // reference model state: 0 = running, 1 = waiting on data memory, 2 = halted
  int m_mode;
  int m_wait_cycles;
  int m_err;
  int m_cnt;

  vec_t tbl[$];

  pipe_hazard_ctrl #(.MEM_TIMEOUT(TB_TMO), .CNT_W(TB_CNT_W)) dut (
    .clk          (clk),
    .rst          (rst),
    .id_rs1       (id_rs1),
    .id_rs2       (id_rs2),
    .id_useRs1    (id_useRs1),
    .id_useRs2    (id_useRs2),
    .ex_rd        (ex_rd),
    .ex_memRead   (ex_memRead),
    .ex_redirect  (ex_redirect),
    .imem_ready   (imem_ready),
    .me_memReq    (me_memReq),
    .dmem_ready   (dmem_ready),
    .halt_req     (halt_req),
    .resume       (resume),
    .pc_en        (pc_en),
    .if_id_en     (if_id_en),
    .id_ex_en     (id_ex_en),
    .ex_me_en     (ex_me_en),
    .me_wb_en     (me_wb_en),
    .if_id_bubble (if_id_bubble),
    .id_ex_bubble (id_ex_bubble),
    .mem_err      (mem_err),
    .halted       (halted),
    .stall_cnt    (stall_cnt)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic in_t mk(input logic r, input logic redir, input logic imr,
                             input logic memreq, input logic dr, input logic hreq,
                             input logic res, input logic exmr, input int exrd,
                             input logic u1, input int rs1, input logic u2, input int rs2);
    in_t v;
    v.rst = r;  v.redir = redir; v.imr = imr; v.memreq = memreq; v.dr = dr;
    v.hreq = hreq; v.resume = res; v.exmr = exmr; v.exrd = 5'(exrd);
    v.u1 = u1; v.rs1 = 5'(rs1); v.u2 = u2; v.rs2 = 5'(rs2);
    return v;
  endfunction

  function automatic in_t idle();
    return mk(0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
  endfunction

  function automatic in_t mem_stall(input logic dr);
    return mk(0, 0, 1, 1, dr, 0, 0, 0, 0, 0, 0, 0, 0);
  endfunction

  task automatic add(input string nm, input in_t v, input logic [6:0] en,
                     input logic err, input logic hlt, input int cnt);
    vec_t e;
    e.name = nm; e.in = v; e.en = en; e.err = err; e.hlt = hlt; e.cnt = cnt;
    tbl.push_back(e);
  endtask

  task automatic drive(input in_t v);
    rst = v.rst; ex_redirect = v.redir; imem_ready = v.imr; me_memReq = v.memreq;
    dmem_ready = v.dr; halt_req = v.hreq; resume = v.resume; ex_memRead = v.exmr;
    ex_rd = v.exrd; id_useRs1 = v.u1; id_rs1 = v.rs1; id_useRs2 = v.u2; id_rs2 = v.rs2;
  endtask

  function automatic logic [6:0] dut_en();
    return {pc_en, if_id_en, id_ex_en, ex_me_en, me_wb_en, if_id_bubble, id_ex_bubble};
  endfunction

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h (t=%0t)", nm, got, exp, $time);
    end
  endtask

  // Outcome of the pipeline rules when data memory is not holding anything back
  function automatic logic [6:0] m_flow(input in_t v);
    bit hazard;
    hazard = v.exmr && (v.exrd != 0) &&
             ((v.u1 && v.rs1 == v.exrd) || (v.u2 && v.rs2 == v.exrd));
    if (v.redir)  return 7'b11111_11;
    if (hazard)   return 7'b00111_01;
    if (!v.imr)   return 7'b01111_10;
    return 7'b11111_00;
  endfunction

  function automatic logic [6:0] m_expect_en(input in_t v);
    if (v.rst) return '0;
    case (m_mode)
      0:       return (v.memreq && !v.dr) ? 7'b0 : m_flow(v);
      1:       return v.dr ? m_flow(v) : 7'b0;
      default: return '0;
    endcase
  endfunction

  task automatic m_step(input in_t v, input logic [6:0] en);
    if (v.rst) begin
      m_mode = 0; m_wait_cycles = 0; m_err = 0; m_cnt = 0;
      return;
    end
    if (m_mode != 2 && !en[6] && m_cnt < CNT_MAX) m_cnt++;
    case (m_mode)
      0: begin
        if (v.memreq && !v.dr) begin
          m_mode = 1;
          m_wait_cycles = 0;
        end else if (v.hreq) begin
          m_mode = 2;
        end
      end
      1: begin
        if (v.dr) begin
          m_mode = 0;
        end else begin
          m_wait_cycles++;
          if (m_wait_cycles >= TB_TMO) begin
            m_err = 1;
            m_mode = 2;
          end
        end
      end
      default: if (v.resume) m_mode = 0;
    endcase
  endtask

  function automatic in_t rand_in();
    in_t v;
    v.rst    = ($urandom_range(0, 63) == 0);
    v.redir  = ($urandom_range(0, 7) == 0);
    v.imr    = ($urandom_range(0, 3) != 0);
    v.memreq = ($urandom_range(0, 2) == 0);
    v.dr     = ($urandom_range(0, 1) == 0);
    v.hreq   = ($urandom_range(0, 15) == 0);
    v.resume = ($urandom_range(0, 3) == 0);
    v.exmr   = ($urandom_range(0, 1) == 0);
    v.exrd   = 5'($urandom_range(0, 3));
    v.u1     = 1'($urandom_range(0, 1));
    v.rs1    = 5'($urandom_range(0, 3));
    v.u2     = 1'($urandom_range(0, 1));
    v.rs2    = 5'($urandom_range(0, 3));
    return v;
  endfunction

  initial begin
    total = 0;
    bad   = 0;
    m_mode = 0; m_wait_cycles = 0; m_err = 0; m_cnt = 0;

    //            rst rd im mq dr hq rs mr rd u1 r1 u2 r2
    add("reset_hold",  mk(1, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0), 7'b00000_00, 0, 0, 0);
    add("idle",        idle(),                                    7'b11111_00, 0, 0, 0);
    add("load_use",    mk(0, 0, 1, 0, 0, 0, 0, 1, 5, 1, 5, 0, 0), 7'b00111_01, 0, 0, 0);
    add("after_lu",    idle(),                                    7'b11111_00, 0, 0, 1);
    add("x0_no_haz",   mk(0, 0, 1, 0, 0, 0, 0, 1, 0, 1, 0, 1, 0), 7'b11111_00, 0, 0, 1);
    add("no_use",      mk(0, 0, 1, 0, 0, 0, 0, 1, 7, 0, 7, 1, 3), 7'b11111_00, 0, 0, 1);
    add("rs2_use",     mk(0, 0, 1, 0, 0, 0, 0, 1, 9, 0, 0, 1, 9), 7'b00111_01, 0, 0, 1);
    add("redir_all",   mk(0, 1, 0, 0, 0, 0, 0, 1, 9, 1, 9, 0, 0), 7'b11111_11, 0, 0, 2);
    add("imem_miss",   mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0), 7'b01111_10, 0, 0, 2);
    add("slow_0",      mem_stall(0),                              7'b00000_00, 0, 0, 3);
    add("slow_1",      mem_stall(0),                              7'b00000_00, 0, 0, 4);
    add("slow_2",      mem_stall(0),                              7'b00000_00, 0, 0, 5);
    add("slow_ready",  mem_stall(1),                              7'b11111_00, 0, 0, 6);
    add("post_slow",   idle(),                                    7'b11111_00, 0, 0, 6);
    add("tmo_enter",   mem_stall(0),                              7'b00000_00, 0, 0, 6);
    add("tmo_w1",      mem_stall(0),                              7'b00000_00, 0, 0, 7);
    add("tmo_w2",      mem_stall(0),                              7'b00000_00, 0, 0, 8);
    add("tmo_w3",      mem_stall(0),                              7'b00000_00, 0, 0, 9);
    add("tmo_w4",      mem_stall(0),                              7'b00000_00, 0, 0, 10);
    add("tmo_halted",  idle(),                                    7'b00000_00, 1, 1, 11);
    add("halt_hold",   mk(0, 1, 0, 1, 0, 0, 0, 1, 2, 1, 2, 0, 0), 7'b00000_00, 1, 1, 11);
    add("resume",      mk(0, 0, 1, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0), 7'b00000_00, 1, 1, 11);
    add("run_err",     idle(),                                    7'b11111_00, 1, 0, 11);
    add("halt_req",    mk(0, 0, 1, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0), 7'b11111_00, 1, 0, 11);
    add("halt_entry",  idle(),                                    7'b00000_00, 1, 1, 11);
    add("resume2",     mk(0, 0, 1, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0), 7'b00000_00, 1, 1, 11);
    add("sat_0",       mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0), 7'b01111_10, 1, 0, 11);
    add("sat_1",       mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0), 7'b01111_10, 1, 0, 12);
    add("sat_2",       mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0), 7'b01111_10, 1, 0, 13);
    add("sat_3",       mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0), 7'b01111_10, 1, 0, 14);
    add("sat_4",       mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0), 7'b01111_10, 1, 0, 15);
    add("sat_hold",    mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0), 7'b01111_10, 1, 0, 15);
    add("sat_idle",    idle(),                                    7'b11111_00, 1, 0, 15);
    add("rw_enter",    mem_stall(0),                              7'b00000_00, 1, 0, 15);
    add("rw_wait",     mem_stall(0),                              7'b00000_00, 1, 0, 15);
    add("rst_midwait", mk(1, 0, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0), 7'b00000_00, 1, 0, 15);
    add("after_rst",   idle(),                                    7'b11111_00, 0, 0, 0);
    add("wlu_enter",   mem_stall(0),                              7'b00000_00, 0, 0, 0);
    add("wlu_ready",   mk(0, 0, 1, 1, 1, 0, 0, 1, 4, 1, 4, 0, 0), 7'b00111_01, 0, 0, 1);
    add("wlu_after",   idle(),                                    7'b11111_00, 0, 0, 2);
    add("late_enter",  mem_stall(0),                              7'b00000_00, 0, 0, 2);
    add("late_w1",     mem_stall(0),                              7'b00000_00, 0, 0, 3);
    add("late_w2",     mem_stall(0),                              7'b00000_00, 0, 0, 4);
    add("late_w3",     mem_stall(0),                              7'b00000_00, 0, 0, 5);
    add("late_ready",  mem_stall(1),                              7'b11111_00, 0, 0, 6);
    add("late_after",  idle(),                                    7'b11111_00, 0, 0, 6);

    // initial reset so registered state is defined before anything is compared
    drive(mk(1, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    repeat (2) @(posedge clk);
    #1;

    foreach (tbl[i]) begin
      drive(tbl[i].in);
      @(negedge clk);
      chk({tbl[i].name, ".en"},     32'(dut_en()),   32'(tbl[i].en));
      chk({tbl[i].name, ".err"},    32'(mem_err),    32'(tbl[i].err));
      chk({tbl[i].name, ".halted"}, 32'(halted),     32'(tbl[i].hlt));
      chk({tbl[i].name, ".cnt"},    32'(stall_cnt),  32'(tbl[i].cnt));
      @(posedge clk);
      #1;
    end

    // randomized phase: resynchronise the model with a reset cycle first
    for (int n = 0; n < N_RAND; n++) begin
      in_t v;
      logic [6:0] exp_en;
      v = (n == 0) ? mk(1, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0) : rand_in();
      drive(v);
      @(negedge clk);
      exp_en = m_expect_en(v);
      if (n > 0) begin
        chk("rand.en",     32'(dut_en()),  32'(exp_en));
        chk("rand.err",    32'(mem_err),   32'(m_err));
        chk("rand.halted", 32'(halted),    32'(m_mode == 2));
        chk("rand.cnt",    32'(stall_cnt), 32'(m_cnt));
      end
      @(posedge clk);
      m_step(v, exp_en);
      #1;
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
